// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, responder state type and the lane-mask helper
// used by the SRAM slave.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   typedef enum logic [1:0] {
      ST_ADDR = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_t;

   function automatic logic [3:0] byte_mask(input logic [2:0] hsize, input logic [1:0] addr);
      case (hsize)
         HSIZE_BYTE: return 4'b0001 << addr;
         HSIZE_HALF: return addr[1] ? 4'b1100 : 4'b0011;
         default:    return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Single-port 32-bit SRAM with per-byte write enables and a registered read
// port; written so synthesis maps it onto block RAM.
module ahb_sram_bank #(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    we,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder backing a master port with on-chip SRAM: wait-state
// insertion, sub-word writes, two-cycle ERROR responses and a write bypass.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_ADDR | HREADY=1; idle or completing a zero-wait write; samples next
// ST_WAIT | data phase stalled while cnt != 0; cnt == 0 completes + samples
// ST_ERR1 | first ERROR cycle, HREADY=0
// ST_ERR2 | second ERROR cycle, HREADY=1, samples next address phase
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int MEM_DEPTH   = 4096,
   parameter int WAIT_STATES = 1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic        HMASTLOCK,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   output logic        HREADY,
   output logic [31:0] HRDATA,
   output logic [1:0]  HRESP
);

   localparam int AW      = $clog2(MEM_DEPTH);
   localparam int RD_WAIT = (WAIT_STATES < 1) ? 1 : WAIT_STATES;
   localparam int CW      = $clog2(RD_WAIT + 1);
   localparam logic [31:0] BYTE_LIMIT = 32'(4 * MEM_DEPTH);

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          dp_valid, dp_valid_nx;
   logic          dp_write, dp_write_nx;
   logic [AW-1:0] dp_addr, dp_addr_nx;
   logic [3:0]    dp_mask, dp_mask_nx;
   logic [31:0]   hrdata_q;

   logic          byp_valid;
   logic [AW-1:0] byp_addr;
   logic [31:0]   byp_data;
   logic [3:0]    byp_mask;

   logic          hready, xfer, xfer_err, wr_done, rd_done;
   logic [1:0]    hresp;
   logic [31:0]   sram_rdata, rd_merged;
   logic          unused_ok;

   assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

   assign xfer = HSEL && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

   always_comb begin
      xfer_err = 1'b0;
      if ((HADDR >> ADDR_WIDTH) != 32'd0 || HADDR >= BYTE_LIMIT) xfer_err = 1'b1;
      if (HSIZE > HSIZE_WORD) xfer_err = 1'b1;
      if (HSIZE == HSIZE_HALF && HADDR[0]) xfer_err = 1'b1;
      if (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00) xfer_err = 1'b1;
   end

   always_comb begin
      hready = 1'b1;
      hresp  = HRESP_OKAY;
      case (state)
         ST_WAIT: hready = (cnt == '0);
         ST_ERR1: begin
            hready = 1'b0;
            hresp  = HRESP_ERROR;
         end
         ST_ERR2: hresp = HRESP_ERROR;
         default: ;
      endcase
   end

   assign wr_done = hready && dp_valid && dp_write;
   assign rd_done = hready && dp_valid && !dp_write;

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      dp_valid_nx = dp_valid;
      dp_write_nx = dp_write;
      dp_addr_nx  = dp_addr;
      dp_mask_nx  = dp_mask;
      if (hready) begin
         state_nx    = ST_ADDR;
         dp_valid_nx = 1'b0;
         dp_write_nx = 1'b0;
         if (xfer) begin
            dp_addr_nx = HADDR[AW+1:2];
            dp_mask_nx = byte_mask(HSIZE, HADDR[1:0]);
            if (xfer_err) begin
               state_nx = ST_ERR1;
            end else begin
               dp_valid_nx = 1'b1;
               dp_write_nx = HWRITE;
               if (HWRITE && WAIT_STATES == 0) begin
                  state_nx = ST_ADDR;
               end else begin
                  state_nx = ST_WAIT;
                  cnt_nx   = HWRITE ? CW'(WAIT_STATES) : CW'(RD_WAIT);
               end
            end
         end
      end else begin
         case (state)
            ST_WAIT: cnt_nx   = cnt - 1'b1;
            ST_ERR1: state_nx = ST_ERR2;
            default: ;
         endcase
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state    <= ST_ADDR;
         cnt      <= '0;
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= '0;
         dp_mask  <= '0;
         hrdata_q <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         dp_valid <= dp_valid_nx;
         dp_write <= dp_write_nx;
         dp_addr  <= dp_addr_nx;
         dp_mask  <= dp_mask_nx;
         if (rd_done) hrdata_q <= rd_merged;
      end
   end

   // Last committed write, merged over the SRAM word when a read hits it.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         byp_valid <= 1'b0;
         byp_addr  <= '0;
         byp_data  <= '0;
         byp_mask  <= '0;
      end else if (wr_done) begin
         byp_valid <= 1'b1;
         byp_addr  <= dp_addr;
         byp_data  <= HWDATA;
         byp_mask  <= dp_mask;
      end
   end

   always_comb begin
      rd_merged = sram_rdata;
      if (byp_valid && byp_addr == dp_addr) begin
         for (int i = 0; i < 4; i++) begin
            if (byp_mask[i]) rd_merged[8*i +: 8] = byp_data[8*i +: 8];
         end
      end
   end

   ahb_sram_bank #(
      .DEPTH (MEM_DEPTH),
      .AW    (AW)
   ) u_bank (
      .clk   (HCLK),
      .addr  (dp_addr),
      .we    (wr_done ? dp_mask : 4'b0000),
      .wdata (HWDATA),
      .rdata (sram_rdata)
   );

   assign HREADY = hready;
   assign HRESP  = hresp;
   assign HRDATA = rd_done ? rd_merged : hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: one instance with one wait state and
// one zero-wait instance, driven by a pipelined AHB master model.
module tb_ahb_sram_slave;
   import ahb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        hreset [2];
   logic        hsel   [2];
   logic [31:0] haddr  [2];
   logic [1:0]  htrans [2];
   logic [2:0]  hsize  [2];
   logic        hwrite [2];
   logic [31:0] hwdata [2];
   logic        hready [2];
   logic [31:0] hrdata [2];
   logic [1:0]  hresp  [2];
   logic [2:0]  hburst = 3'b001;
   logic [3:0]  hprot  = 4'b0011;
   logic        hlock  = 1'b0;

   ahb_sram_slave #(.WAIT_STATES(1)) dut_ws1 (
      .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
      .HTRANS(htrans[0]), .HSIZE(hsize[0]), .HBURST(hburst), .HPROT(hprot),
      .HMASTLOCK(hlock), .HWRITE(hwrite[0]), .HWDATA(hwdata[0]),
      .HREADY(hready[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0])
   );

   ahb_sram_slave #(.WAIT_STATES(0)) dut_ws0 (
      .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
      .HTRANS(htrans[1]), .HSIZE(hsize[1]), .HBURST(hburst), .HPROT(hprot),
      .HMASTLOCK(hlock), .HWRITE(hwrite[1]), .HWDATA(hwdata[1]),
      .HREADY(hready[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1])
   );

   typedef struct {
      logic        rd;
      logic [31:0] data;
      logic [1:0]  resp;
      int          waits;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int total = 0;
   int bad   = 0;
   logic [31:0] pend_wdata [2];

   task automatic check(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL dut%0d %s actual=%h expected=%h", d, name, act, exp);
      end
   endtask

   task automatic wait_ready(input int d);
      int n = 0;
      while (!hready[d]) begin
         @(posedge clk); #1;
         n++;
         if (n > 30) begin
            total++;
            bad++;
            $display("FAIL dut%0d hready_timeout cycles=%0d expected<=30", d, n);
            break;
         end
      end
   endtask

   // One address phase; HWDATA carries the previous beat's data phase.
   task automatic beat(input int d, input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      hsel[d]   = sel;
      htrans[d] = trans;
      hwrite[d] = wr;
      hsize[d]  = size;
      haddr[d]  = addr;
      hwdata[d] = pend_wdata[d];
      wait_ready(d);
      @(posedge clk); #1;
      pend_wdata[d] = wdata;
   endtask

   task automatic xfer(input int d, input logic [1:0] trans, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] resp,
                       input int waits, input logic [31:0] rdata);
      exp_t e;
      e.rd    = !wr;
      e.data  = rdata;
      e.resp  = resp;
      e.waits = waits;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      beat(d, 1'b1, trans, wr, size, addr, wdata);
   endtask

   task automatic idle(input int d, input logic sel, input logic [1:0] trans);
      beat(d, sel, trans, 1'b0, HSIZE_WORD, 32'h0, 32'h0);
   endtask

   task automatic monitor(input int d);
      logic       pend = 1'b0;
      int         waits = 0;
      logic [1:0] low_resp = 2'b00;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (hreset[d]) begin
            pend = 1'b0;
            continue;
         end
         if (pend) begin
            if (!hready[d]) begin
               if (waits == 0) low_resp = hresp[d];
               waits++;
               if (waits > 30) begin
                  total++;
                  bad++;
                  $display("FAIL dut%0d data_phase_timeout waits=%0d expected<=30", d, waits);
                  pend = 1'b0;
               end
            end else begin
               pend = 1'b0;
               if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                  total++;
                  bad++;
                  $display("FAIL dut%0d unexpected_completion actual=1 expected=0", d);
               end else begin
                  e = (d == 0) ? q0.pop_front() : q1.pop_front();
                  check(d, "hresp", 32'(hresp[d]), 32'(e.resp));
                  check(d, "wait_cycles", waits, e.waits);
                  if (waits > 0) check(d, "hresp_while_stalled", 32'(low_resp), 32'(e.resp));
                  if (e.rd && e.resp == HRESP_OKAY) check(d, "hrdata", hrdata[d], e.data);
               end
            end
         end else begin
            check(d, "idle_hready", 32'(hready[d]), 32'd1);
            check(d, "idle_hresp", 32'(hresp[d]), 32'(HRESP_OKAY));
         end
         if (!pend && hready[d] && hsel[d] && htrans[d][1]) begin
            pend  = 1'b1;
            waits = 0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         hreset[d] = 1'b1;
         hsel[d] = 1'b0;
         haddr[d] = '0;
         htrans[d] = HTRANS_IDLE;
         hsize[d] = HSIZE_WORD;
         hwrite[d] = 1'b0;
         hwdata[d] = '0;
         pend_wdata[d] = '0;
      end
      fork
         monitor(0);
         monitor(1);
      join_none
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check(d, "reset_hready", 32'(hready[d]), 32'd1);
         check(d, "reset_hresp", 32'(hresp[d]), 32'd0);
         check(d, "reset_hrdata", hrdata[d], 32'd0);
      end
      @(negedge clk);
      hreset[0] = 1'b0;
      hreset[1] = 1'b0;
      @(posedge clk); #1;

      // word write then read, one wait each
      xfer(0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'hDEADBEEF, HRESP_OKAY, 1, 0);
      xfer(0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 0, HRESP_OKAY, 1, 32'hDEADBEEF);

      // byte lanes then a halfword over the upper half
      xfer(0, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h20, 32'h00000011, HRESP_OKAY, 1, 0);
      xfer(0, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h21, 32'h00002200, HRESP_OKAY, 1, 0);
      xfer(0, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h22, 32'h00330000, HRESP_OKAY, 1, 0);
      xfer(0, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h23, 32'h44000000, HRESP_OKAY, 1, 0);
      xfer(0, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h22, 32'hAABB0000, HRESP_OKAY, 1, 0);
      xfer(0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 0, HRESP_OKAY, 1, 32'hAABB2211);

      // illegal transfers; several would alias word 0x10 if decoded loosely
      xfer(0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h02, 0, HRESP_ERROR, 1, 0);
      xfer(0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h0001_0010, 32'h55555555, HRESP_ERROR, 1, 0);
      xfer(0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h4010, 32'h66666666, HRESP_ERROR, 1, 0);
      xfer(0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h12, 32'h77777777, HRESP_ERROR, 1, 0);
      xfer(0, HTRANS_NONSEQ, 1, 3'b011, 32'h10, 32'h88888888, HRESP_ERROR, 1, 0);
      xfer(0, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h11, 32'h99999999, HRESP_ERROR, 1, 0);
      xfer(0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 0, HRESP_OKAY, 1, 32'hDEADBEEF);

      // burst with idle, busy and deselected cycles in between
      xfer(0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h100, 32'hA0A00001, HRESP_OKAY, 1, 0);
      idle(0, 1'b1, HTRANS_IDLE);
      xfer(0, HTRANS_SEQ, 1, HSIZE_WORD, 32'h104, 32'hA0A00002, HRESP_OKAY, 1, 0);
      idle(0, 1'b1, HTRANS_BUSY);
      xfer(0, HTRANS_SEQ, 1, HSIZE_WORD, 32'h108, 32'hA0A00003, HRESP_OKAY, 1, 0);
      idle(0, 1'b0, HTRANS_SEQ);
      xfer(0, HTRANS_SEQ, 1, HSIZE_WORD, 32'h10C, 32'hA0A00004, HRESP_OKAY, 1, 0);
      xfer(0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h100, 0, HRESP_OKAY, 1, 32'hA0A00001);
      xfer(0, HTRANS_SEQ, 0, HSIZE_WORD, 32'h104, 0, HRESP_OKAY, 1, 32'hA0A00002);
      idle(0, 1'b1, HTRANS_BUSY);
      xfer(0, HTRANS_SEQ, 0, HSIZE_WORD, 32'h108, 0, HRESP_OKAY, 1, 32'hA0A00003);
      idle(0, 1'b0, HTRANS_SEQ);
      xfer(0, HTRANS_SEQ, 0, HSIZE_WORD, 32'h10C, 0, HRESP_OKAY, 1, 32'hA0A00004);
      idle(0, 1'b0, HTRANS_IDLE);

      // reset during the wait of a write
      xfer(0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h80, 32'h01020304, HRESP_OKAY, 1, 0);
      idle(0, 1'b0, HTRANS_IDLE);
      hsel[0] = 1'b1;
      htrans[0] = HTRANS_NONSEQ;
      hwrite[0] = 1'b1;
      hsize[0] = HSIZE_WORD;
      haddr[0] = 32'h80;
      hwdata[0] = pend_wdata[0];
      @(posedge clk); #1;
      hsel[0] = 1'b0;
      htrans[0] = HTRANS_IDLE;
      hwdata[0] = 32'hFFFFFFFF;
      check(0, "stall_before_reset", 32'(hready[0]), 32'd0);
      #2 hreset[0] = 1'b1;
      #1;
      check(0, "reset_abort_hready", 32'(hready[0]), 32'd1);
      check(0, "reset_abort_hresp", 32'(hresp[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      hreset[0] = 1'b0;
      @(posedge clk); #1;
      pend_wdata[0] = '0;
      xfer(0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h80, 0, HRESP_OKAY, 1, 32'h01020304);
      idle(0, 1'b0, HTRANS_IDLE);

      // zero-wait writes followed directly by reads
      xfer(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h40, 32'h12345678, HRESP_OKAY, 0, 0);
      xfer(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h40, 0, HRESP_OKAY, 1, 32'h12345678);
      xfer(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h41, 32'h0000CD00, HRESP_OKAY, 0, 0);
      xfer(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h40, 0, HRESP_OKAY, 1, 32'h1234CD78);
      xfer(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h43, 32'hEEEE0000, HRESP_ERROR, 1, 0);
      xfer(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h40, 0, HRESP_OKAY, 1, 32'h1234CD78);
      idle(1, 1'b0, HTRANS_IDLE);

      repeat (4) @(posedge clk);
      #1;
      check(0, "scoreboard_empty", q0.size(), 32'd0);
      check(1, "scoreboard_empty", q1.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave (responder) that backs a processor AHB master port (MEM or MMIO) with on-chip SRAM.
- Decodes address-phase controls, inserts a configurable number of wait states and performs byte/halfword/word reads and writes.
- Returns a two-cycle ERROR response for illegal transfers.
- Single slave per master port; no HREADYIN, because this block's HREADY is the bus HREADY.

Parameters:
- ADDR_WIDTH, 16: byte-address bits decoded; HADDR[31:ADDR_WIDTH] must be zero, otherwise the transfer errors.
- MEM_DEPTH, 4096: number of 32-bit words; byte offset >= 4*MEM_DEPTH errors.
- WAIT_STATES, 1: wait cycles inserted per valid transfer; reads always use max(WAIT_STATES,1).

Ports:
- HCLK  in  1  bus clock; the only clock.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HSIZE  in  3  000 byte, 001 half, 010 word.
- HBURST  in  3  ignored; each beat is handled independently.
- HPROT  in  4  ignored.
- HMASTLOCK  in  1  ignored.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  out  1  transfer done / accept next address phase.
- HRDATA  out  32  read data.
- HRESP  out  2  bit0 = ERROR; bit1 is tied to 0.

Behaviour:
- Reset (asynchronous assert, synchronous-release usage): state=ADDR, HREADY=1, HRESP=00, HRDATA=0, all captured registers 0. SRAM contents are not cleared.
- Address phase is sampled on each rising HCLK edge where HREADY=1. A transfer is valid when HSEL=1 and HTRANS[1]=1.
- IDLE, BUSY or HSEL=0: no action; the next cycle reports HREADY=1, HRESP=00.
- Error conditions, evaluated in the address phase:
  - HADDR out of range.
  - HSIZE > 010.
  - Misalignment: half with HADDR[0]=1, or word with HADDR[1:0]!=0.
- State machine:
  - ADDR: waits for a sampled transfer. Legal transfer -> WAIT, or -> ADDR with HREADY=1 for a zero-wait write. Illegal transfer -> ERR1.
  - WAIT: down-counter loaded with the wait count; HREADY=0, HRESP=00. When the counter reaches 0, HREADY=1 for exactly one cycle, then ADDR, which samples the next address phase the same cycle.
  - ERR1: HREADY=0, HRESP=01.
  - ERR2: HREADY=1, HRESP=01, then ADDR. Memory is untouched on any errored transfer.
- Writes:
  - Byte enables come from HSIZE and HADDR[1:0]: byte -> one lane; half -> lanes {1,0} or {3,2}; word -> all lanes.
  - The SRAM write occurs on the edge at which the data phase completes (HREADY=1), using HWDATA from that cycle.
- Reads:
  - The SRAM is registered-read. The word address is presented in the first data-phase cycle, and data is valid at HRDATA in the cycle HREADY=1.
  - The full word is returned; the master selects lanes.
  - HRDATA holds its last value outside read completion.
- Read-after-write: with WAIT_STATES=0, a read directly following a write to the same word must return the merged write data. Implement this with a bypass: registered last-write word + byte mask.
- Back-to-back transfers are pipelined: the next address phase is sampled in the same cycle the current data phase completes.
- Reset mid-transfer aborts the transfer. A pending write is not committed unless its completing edge preceded the reset.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings.
  - HSIZE encodings.
  - HRESP encodings (OKAY=2'b00, ERROR=2'b01).
  - State enum {ADDR, WAIT, ERR1, ERR2}.
  - Function byte_mask(hsize, addr[1:0]) -> 4-bit lane mask.
- Sub-module ahb_sram_bank: single-port 32-bit SRAM with 4-bit byte-write enable and registered read, inferring LSRAM.

Test Plan:
- Word write 0xDEADBEEF @0x0010, then word read @0x0010 with WAIT_STATES=1 -> write completes after 1 wait; read HREADY low 1 cycle, HRDATA=0xDEADBEEF, HRESP=00.
- Byte writes 0x11,0x22,0x33,0x44 to 0x20..0x23, then halfword 0xAABB @0x22 -> word read @0x20 returns 0xAABB2211.
- WAIT_STATES=0: write 0x12345678 @0x40, then immediate read @0x40 -> write is zero-wait; read returns 0x12345678 via bypass after 1 wait.
- Word read @0x0002 (misaligned) and write @0x0001_0000 (out of range) -> each gives HREADY=0/HRESP=01 then HREADY=1/HRESP=01; a follow-up read shows memory unchanged.
- IDLE, BUSY and HSEL=0 cycles interleaved with a SEQ burst of 4 words @0x100 -> no waits on the idle/busy/unselected cycles; burst data is correct and HRESP stays 00.
- HRESET asserted during the WAIT of a write @0x80 -> HREADY=1, HRESP=00 immediately; read @0x80 after release returns the old value.
